// File: rtl/kfmmc_pkg.sv
// Shared types for the reset sequencer: FSM states, restart counter width, saturating increment.
package kfmmc_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_POR_COUNT,
        ST_RELEASE,
        ST_RUN
    } seq_state_t;

    localparam int RESTART_W = 8;

    function automatic logic [RESTART_W-1:0] sat_inc(input logic [RESTART_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/kfmmc_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; 2-cycle latency, no backpressure.
module kfmmc_sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/kfmmc_reset_sequencer.sv
// Qualifies PLL lock, counts a POR interval, then releases channel resets one by one.
// All outputs registered; lock loss or soft request restarts the sequence.
module kfmmc_reset_sequencer
    import kfmmc_pkg::*;
#(
    parameter int POR_CYCLES    = 16'hFFFF,
    parameter int CNT_WIDTH     = 16,
    parameter int CHANNELS      = 3,
    parameter int STAGE_GAP     = 256,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pll_locked,
    input  logic                 soft_reset_request,
    output logic [CHANNELS-1:0]  channel_reset,
    output logic                 sequencing,
    output logic                 all_released,
    output logic [RESTART_W-1:0] restart_count
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_WIDTH-1:0] POR_LAST   = CNT_WIDTH'(POR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'(STAGE_GAP - 1);
    localparam logic [FW-1:0]        FILT_LAST  = FW'(FILTER_CYCLES - 1);
    localparam logic [SW-1:0]        STAGE_LAST = SW'(CHANNELS - 1);

    logic lock_s;

    kfmmc_sync_2ff u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );

    seq_state_t             state_q, state_n;
    logic [CNT_WIDTH-1:0]   por_cnt_q, por_cnt_n;
    logic [CNT_WIDTH-1:0]   gap_cnt_q, gap_cnt_n;
    logic [FW-1:0]          filt_q, filt_n;
    logic [SW-1:0]          stage_q, stage_n;
    logic [CHANNELS-1:0]    chan_q, chan_n;
    logic                   seq_n, all_n;
    logic [RESTART_W-1:0]   rc_q, rc_n;

    always_comb begin
        state_n   = state_q;
        por_cnt_n = por_cnt_q;
        gap_cnt_n = gap_cnt_q;
        filt_n    = filt_q;
        stage_n   = stage_q;
        chan_n    = chan_q;
        rc_n      = rc_q;

        unique case (state_q)
            ST_HOLD: begin
                chan_n = '1;
                if (!lock_s) begin
                    filt_n = '0;
                end else if (filt_q == FILT_LAST) begin
                    filt_n    = '0;
                    por_cnt_n = '0;
                    state_n   = ST_POR_COUNT;
                end else begin
                    filt_n = filt_q + 1'b1;
                end
            end
            ST_POR_COUNT: begin
                if (por_cnt_q == POR_LAST) begin
                    chan_n    = '1;
                    chan_n[0] = 1'b0;
                    stage_n   = SW'(1);
                    gap_cnt_n = '0;
                    state_n   = (CHANNELS == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    por_cnt_n = por_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_n       = '0;
                    chan_n[stage_q] = 1'b0;
                    if (stage_q == STAGE_LAST) begin
                        state_n = ST_RUN;
                    end else begin
                        stage_n = stage_q + 1'b1;
                    end
                end else begin
                    gap_cnt_n = gap_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Lock loss overrides everything after HOLD, including a same-cycle soft request.
        if (state_q != ST_HOLD && !lock_s) begin
            state_n   = ST_HOLD;
            chan_n    = '1;
            por_cnt_n = '0;
            gap_cnt_n = '0;
            filt_n    = '0;
            stage_n   = '0;
            rc_n      = sat_inc(rc_q);
        end else if ((state_q == ST_RELEASE || state_q == ST_RUN) && soft_reset_request) begin
            state_n   = ST_POR_COUNT;
            chan_n    = '1;
            por_cnt_n = '0;
            gap_cnt_n = '0;
            stage_n   = '0;
            rc_n      = sat_inc(rc_q);
        end

        seq_n = (state_n == ST_POR_COUNT) || (state_n == ST_RELEASE);
        all_n = (state_n == ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_HOLD;
            por_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            filt_q        <= '0;
            stage_q       <= '0;
            chan_q        <= '1;
            sequencing    <= 1'b0;
            all_released  <= 1'b0;
            rc_q          <= '0;
        end else begin
            state_q       <= state_n;
            por_cnt_q     <= por_cnt_n;
            gap_cnt_q     <= gap_cnt_n;
            filt_q        <= filt_n;
            stage_q       <= stage_n;
            chan_q        <= chan_n;
            sequencing    <= seq_n;
            all_released  <= all_n;
            rc_q          <= rc_n;
        end
    end

    assign channel_reset = chan_q;
    assign restart_count = rc_q;

endmodule

// File: tb/tb_kfmmc_reset_sequencer.sv
// Directed bench: per-cycle vector table plus hand sequences for mid-POR reset and saturation.
module tb_kfmmc_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       soft_reset_request;
    logic [2:0] channel_reset;
    logic       sequencing;
    logic       all_released;
    logic [7:0] restart_count;

    int total = 0;
    int bad   = 0;

    kfmmc_reset_sequencer #(
        .POR_CYCLES    (8),
        .CNT_WIDTH     (16),
        .CHANNELS      (3),
        .STAGE_GAP     (4),
        .FILTER_CYCLES (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .pll_locked         (pll_locked),
        .soft_reset_request (soft_reset_request),
        .channel_reset      (channel_reset),
        .sequencing         (sequencing),
        .all_released       (all_released),
        .restart_count      (restart_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       lk;
        logic       sr;
        logic [2:0] ch;
        logic       sq;
        logic       al;
        logic [7:0] rc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int n, input logic rst, input logic lk, input logic sr,
                       input logic [2:0] ch, input logic sq, input logic al, input logic [7:0] rc);
        vec_t v;
        v.rst = rst; v.lk = lk; v.sr = sr; v.ch = ch; v.sq = sq; v.al = al; v.rc = rc;
        repeat (n) vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_rel(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step(1);
            if (all_released) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    bit ok;
    int n;

    initial begin
        reset = 1'b1; pll_locked = 1'b0; soft_reset_request = 1'b0;

        // Lock glitch during filtering: POR entry slips from edge 4 to edge 6.
        add(1, 1, 1, 0, 3'b111, 0, 0, 0);
        add(1, 0, 1, 0, 3'b111, 0, 0, 0);
        add(1, 0, 0, 0, 3'b111, 0, 0, 0);
        add(3, 0, 1, 0, 3'b111, 0, 0, 0);
        add(1, 0, 1, 0, 3'b111, 1, 0, 0);
        // Clean start; soft request in HOLD ignored; staggered release; then lock loss in RUN.
        add(1, 1, 1, 0, 3'b111, 0, 0, 0);
        add(1, 0, 1, 1, 3'b111, 0, 0, 0);
        add(2, 0, 1, 0, 3'b111, 0, 0, 0);
        add(8, 0, 1, 0, 3'b111, 1, 0, 0);
        add(4, 0, 1, 0, 3'b110, 1, 0, 0);
        add(4, 0, 1, 0, 3'b100, 1, 0, 0);
        add(2, 0, 1, 0, 3'b000, 0, 1, 0);
        add(2, 0, 0, 0, 3'b000, 0, 1, 0);
        add(2, 0, 0, 0, 3'b111, 0, 0, 1);
        // Soft request in RELEASE, soft ignored in POR, then lock loss coinciding with soft.
        add(1, 1, 1, 0, 3'b111, 0, 0, 0);
        add(3, 0, 1, 0, 3'b111, 0, 0, 0);
        add(8, 0, 1, 0, 3'b111, 1, 0, 0);
        add(2, 0, 1, 0, 3'b110, 1, 0, 0);
        add(1, 0, 1, 1, 3'b111, 1, 0, 1);
        add(2, 0, 1, 0, 3'b111, 1, 0, 1);
        add(1, 0, 1, 1, 3'b111, 1, 0, 1);
        add(4, 0, 1, 0, 3'b111, 1, 0, 1);
        add(4, 0, 1, 0, 3'b110, 1, 0, 1);
        add(4, 0, 1, 0, 3'b100, 1, 0, 1);
        add(2, 0, 1, 0, 3'b000, 0, 1, 1);
        add(2, 0, 0, 0, 3'b000, 0, 1, 1);
        add(1, 0, 0, 1, 3'b111, 0, 0, 2);
        add(1, 0, 0, 0, 3'b111, 0, 0, 2);

        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst;
            pll_locked = vq[i].lk;
            soft_reset_request = vq[i].sr;
            step(1);
            chk($sformatf("vec%0d", i),
                {19'd0, channel_reset, sequencing, all_released, restart_count},
                {19'd0, vq[i].ch, vq[i].sq, vq[i].al, vq[i].rc});
        end

        // Reset asserted while the POR counter holds 5.
        reset = 1'b1; soft_reset_request = 1'b0; pll_locked = 1'b1;
        step(1);
        reset = 1'b0;
        step(9);
        chk("por_cnt5_seq", {31'd0, sequencing}, 32'd1);
        reset = 1'b1;
        step(1);
        chk("mid_por_reset", {24'd0, channel_reset, sequencing, all_released, restart_count[0]},
            {24'd0, 3'b111, 1'b0, 1'b0, 1'b0});
        chk("mid_por_reset_rc", {24'd0, restart_count}, 32'd0);
        step(1);
        reset = 1'b0;
        n = 0;
        while (!sequencing && n < 50) begin
            step(1);
            n++;
        end
        chk("restart_por_entry", n, 4);
        n = 0;
        while (channel_reset == 3'b111 && n < 50) begin
            step(1);
            n++;
        end
        chk("restart_ch0_drop", n, 8);
        chk("restart_ch0_val", {29'd0, channel_reset}, {29'd0, 3'b110});

        // Many soft requests in RUN: restart_count saturates.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        wait_rel(100, ok);
        chk("sat_first_run", {31'd0, ok}, 32'd1);
        for (int r = 1; r <= 300; r++) begin
            soft_reset_request = 1'b1;
            step(1);
            soft_reset_request = 1'b0;
            wait_rel(50, ok);
            chk($sformatf("sat_rerun%0d", r), {31'd0, ok}, 32'd1);
            if (!ok) break;
            if (r == 254) chk("rc_254", {24'd0, restart_count}, 32'd254);
            if (r == 255) chk("rc_255", {24'd0, restart_count}, 32'd255);
        end
        chk("rc_saturated", {24'd0, restart_count}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
